// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/mask registers and a single registered request to the decoder.
// Define IRQ_CTRL_EDGE_EN for edge-triggered sources; level-triggered sources otherwise.
module irq_ctrl #(
    parameter int NB_IRQ = 32
) (
    input  logic              clk,
    input  logic              reset_n_i,
    input  logic [NB_IRQ-1:0] irq_src_i,
    input  logic              take_i,
    input  logic              set_mask_i,
    input  logic [31:0]       mask_i,
    input  logic              eoi_i,
    output logic              irq_o,
    output logic [31:0]       cause_o,
    output logic [31:0]       mask_o,
    output logic [31:0]       pending_o,
    output logic              in_service_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic        irq_reg, irq_next;
    logic        in_service_reg, in_service_next;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] pending_reg, pending_next;
    logic [31:0] mask_reg, mask_next;
    logic [31:0] src_ext;
    logic [31:0] valid;
    logic [31:0] set_p;
    logic [31:0] clr;
    logic [31:0] unmasked;
    logic        avail;

    // Widen sources to the 32-bit register width; unused lanes are tied off.
    for (genvar gi = 0; gi < 32; gi++) begin : g_lane
        if (gi < NB_IRQ) begin : g_used
            assign src_ext[gi] = irq_src_i[gi];
            assign valid[gi]   = 1'b1;
        end else begin : g_unused
            assign src_ext[gi] = 1'b0;
            assign valid[gi]   = 1'b0;
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [31:0] src_q;

    // History follows the live level even during reset, so a line held high
    // across reset needs a fresh rising edge before it sets pending again.
    always_ff @(posedge clk) begin
        src_q <= src_ext;
    end

    assign set_p = src_ext & ~src_q;
`else
    assign set_p = src_ext;
`endif

    assign unmasked = pending_reg & ~mask_reg;
    assign avail    = |unmasked;

    always_comb begin
        state_next      = state_reg;
        irq_next        = irq_reg;
        in_service_next = in_service_reg;
        cause_next      = cause_reg;
        clr             = 32'h0;
        case (state_reg)
            IDLE: begin
                if (avail) begin
                    state_next = REQ;
                    irq_next   = 1'b1;
                end
            end
            REQ: begin
                // Acceptance uses the registered mask, so it wins over a same-cycle mask write.
                if (take_i) begin
                    state_next      = SVC;
                    cause_next      = unmasked;
                    clr             = unmasked;
                    irq_next        = 1'b0;
                    in_service_next = 1'b1;
                end else if (!avail) begin
                    state_next = IDLE;
                    irq_next   = 1'b0;
                end
            end
            SVC: begin
                if (eoi_i) begin
                    state_next      = IDLE;
                    in_service_next = 1'b0;
                end
            end
            default: begin
                state_next      = IDLE;
                irq_next        = 1'b0;
                in_service_next = 1'b0;
            end
        endcase
        pending_next = (pending_reg & ~clr) | set_p;
        mask_next    = set_mask_i ? (mask_i & valid) : mask_reg;
    end

    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_reg      <= IDLE;
            irq_reg        <= 1'b0;
            in_service_reg <= 1'b0;
            cause_reg      <= 32'h0;
            pending_reg    <= 32'h0;
            mask_reg       <= valid;
        end else begin
            state_reg      <= state_next;
            irq_reg        <= irq_next;
            in_service_reg <= in_service_next;
            cause_reg      <= cause_next;
            pending_reg    <= pending_next;
            mask_reg       <= mask_next;
        end
    end

    assign irq_o        = irq_reg;
    assign cause_o      = cause_reg;
    assign mask_o       = mask_reg;
    assign pending_o    = pending_reg;
    assign in_service_o = in_service_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: stimulus pushes cycle-tagged expected outputs,
// a monitor on the falling edge pops and compares them.
module tb_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [31:0] irq_src;
    logic        take;
    logic        set_mask;
    logic [31:0] mask_in;
    logic        eoi;
    logic        irq;
    logic [31:0] cause;
    logic [31:0] mask;
    logic [31:0] pending;
    logic        in_service;

    typedef struct {
        int          cyc;
        string       name;
        logic        irq;
        logic [31:0] cause;
        logic [31:0] pend;
        logic [31:0] mask;
        logic        insvc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    irq_ctrl #(.NB_IRQ(32)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n),
        .irq_src_i    (irq_src),
        .take_i       (take),
        .set_mask_i   (set_mask),
        .mask_i       (mask_in),
        .eoi_i        (eoi),
        .irq_o        (irq),
        .cause_o      (cause),
        .mask_o       (mask),
        .pending_o    (pending),
        .in_service_o (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input int delta, input string name, input logic e_irq,
                            input logic [31:0] e_cause, input logic [31:0] e_pend,
                            input logic [31:0] e_mask, input logic e_insvc);
        exp_t e;
        e.cyc   = cyc + delta;
        e.name  = name;
        e.irq   = e_irq;
        e.cause = e_cause;
        e.pend  = e_pend;
        e.mask  = e_mask;
        e.insvc = e_insvc;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every expectation tagged with the current cycle.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc == cyc) begin
                checks = checks + 1;
                if ({irq, cause, pending, mask, in_service} !==
                    {exp_q[i].irq, exp_q[i].cause, exp_q[i].pend, exp_q[i].mask, exp_q[i].insvc}) begin
                    errors = errors + 1;
                    $display("FAIL %s cyc=%0d got irq=%0b cause=%h pend=%h mask=%h insvc=%0b exp irq=%0b cause=%h pend=%h mask=%h insvc=%0b",
                             exp_q[i].name, cyc, irq, cause, pending, mask, in_service,
                             exp_q[i].irq, exp_q[i].cause, exp_q[i].pend, exp_q[i].mask, exp_q[i].insvc);
                end else begin
                    $display("ok   %s cyc=%0d irq=%0b cause=%h pend=%h mask=%h insvc=%0b",
                             exp_q[i].name, cyc, irq, cause, pending, mask, in_service);
                end
                exp_q.delete(i);
            end else if (exp_q[i].cyc < cyc) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL %s stale expectation for cyc=%0d at cyc=%0d", exp_q[i].name, exp_q[i].cyc, cyc);
                exp_q.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    localparam logic [31:0] M_ALL = 32'hFFFF_FFFF;
    localparam logic [31:0] M_FE  = 32'hFFFF_FFFE;
    localparam logic [31:0] M_F6  = 32'hFFFF_FFF6;
`ifdef IRQ_CTRL_EDGE_EN
    localparam logic [31:0] HELD_PEND = 32'h0;
`else
    localparam logic [31:0] HELD_PEND = 32'h1;
`endif

    initial begin
        reset_n  = 1'b0;
        irq_src  = 32'h0;
        take     = 1'b0;
        set_mask = 1'b0;
        mask_in  = 32'h0;
        eoi      = 1'b0;

        @(negedge clk);
        push_exp(1, "reset", 1'b0, 32'h0, 32'h0, M_ALL, 1'b0);
        @(negedge clk); reset_n = 1'b1; set_mask = 1'b1; mask_in = M_FE;
        push_exp(1, "mask_write", 1'b0, 32'h0, 32'h0, M_FE, 1'b0);
        @(negedge clk); set_mask = 1'b0; irq_src = 32'h1;
        push_exp(1, "pend_set", 1'b0, 32'h0, 32'h1, M_FE, 1'b0);
        push_exp(2, "irq_rise", 1'b1, 32'h0, 32'h1, M_FE, 1'b0);
        @(negedge clk); irq_src = 32'h0;
        @(negedge clk); take = 1'b1;
        push_exp(1, "accept", 1'b0, 32'h1, 32'h0, M_FE, 1'b1);
        @(negedge clk); take = 1'b0; irq_src = 32'h8; set_mask = 1'b1; mask_in = M_F6;
        push_exp(1, "svc_src", 1'b0, 32'h1, 32'h8, M_F6, 1'b1);
        @(negedge clk); irq_src = 32'h0; set_mask = 1'b0; eoi = 1'b1;
        push_exp(1, "eoi", 1'b0, 32'h1, 32'h8, M_F6, 1'b0);
        push_exp(2, "irq_again", 1'b1, 32'h1, 32'h8, M_F6, 1'b0);
        @(negedge clk); eoi = 1'b0;
        @(negedge clk); take = 1'b1;
        push_exp(1, "accept2", 1'b0, 32'h8, 32'h0, M_F6, 1'b1);
        @(negedge clk); take = 1'b0; eoi = 1'b1;
        push_exp(1, "eoi2", 1'b0, 32'h8, 32'h0, M_F6, 1'b0);
        @(negedge clk); take = 1'b1;
        push_exp(1, "ignored", 1'b0, 32'h8, 32'h0, M_F6, 1'b0);
        @(negedge clk); take = 1'b0; eoi = 1'b0; irq_src = 32'h1;
        push_exp(1, "pend_w", 1'b0, 32'h8, 32'h1, M_F6, 1'b0);
        push_exp(2, "req_w", 1'b1, 32'h8, 32'h1, M_F6, 1'b0);
        @(negedge clk); irq_src = 32'h0;
        @(negedge clk); set_mask = 1'b1; mask_in = M_ALL;
        push_exp(1, "mask_in_req", 1'b1, 32'h8, 32'h1, M_ALL, 1'b0);
        push_exp(2, "withdraw", 1'b0, 32'h8, 32'h1, M_ALL, 1'b0);
        @(negedge clk); set_mask = 1'b0;
        @(negedge clk); set_mask = 1'b1; mask_in = M_FE;
        push_exp(2, "re_req", 1'b1, 32'h8, 32'h1, M_FE, 1'b0);
        @(negedge clk); set_mask = 1'b0;
        @(negedge clk); take = 1'b1; irq_src = 32'h1; set_mask = 1'b1; mask_in = M_ALL;
        push_exp(1, "set_wins", 1'b0, 32'h1, 32'h1, M_ALL, 1'b1);
        @(negedge clk); take = 1'b0; irq_src = 32'h0; set_mask = 1'b0;
        push_exp(1, "svc_hold", 1'b0, 32'h1, 32'h1, M_ALL, 1'b1);
        @(negedge clk); reset_n = 1'b0; irq_src = 32'h1;
        push_exp(1, "reset_svc", 1'b0, 32'h0, 32'h0, M_ALL, 1'b0);
        @(negedge clk); reset_n = 1'b1;
        push_exp(1, "post_reset", 1'b0, 32'h0, HELD_PEND, M_ALL, 1'b0);
        @(negedge clk); irq_src = 32'h0;
        push_exp(1, "post_reset2", 1'b0, 32'h0, HELD_PEND, M_ALL, 1'b0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
